ahb3lite_arbiter_2m: RTL and testbench
======================================

# ahb3lite_arbiter_2m

Two-master to one-slave AHB-Lite arbiter. It lets the Cortex-M0 wrapper (master 0) share the interconnect slave path, or a single SRAM, with a second master such as a boot loader or DMA (master 1). Each master port has a one-entry address holding buffer, so a master whose address phase loses arbitration is accepted and then stalled in its data phase. The AHB-Lite protocol at each master port stays legal.

## Interface
Parameters:
- HADDR_SIZE, 32, address width
- HDATA_SIZE, 32, data width

Ports (k = 0, 1):
- hclk_i  in  1  clock; all logic is on the rising edge
- hreset_n_i  in  1  asynchronous, active-low reset
- mk_haddr_i  in  HADDR_SIZE  master k address
- mk_htrans_i  in  2  master k transfer type
- mk_hwrite_i  in  1  master k write
- mk_hsize_i  in  3  master k size
- mk_hburst_i  in  3  master k burst
- mk_hprot_i  in  4  master k protection
- mk_hmastlock_i  in  1  master k lock (forwarded only, not acted on)
- mk_hwdata_i  in  HDATA_SIZE  master k write data
- mk_hrdata_o  out  HDATA_SIZE  read data, equal to s_hrdata_i for both masters
- mk_hready_o  out  1  master k ready
- mk_hresp_o  out  1  master k response
- s_haddr_o, s_htrans_o, s_hwrite_o, s_hsize_o, s_hburst_o, s_hprot_o, s_hmastlock_o  out  widths as above  muxed address/control to slave
- s_hwdata_o  out  HDATA_SIZE  write data of the data-phase owner
- s_hrdata_i  in  HDATA_SIZE  slave read data
- s_hready_i  in  1  slave ready
- s_hresp_i  in  1  slave response
- owner_o  out  1  current address-phase grant, for debug and ILA

## Operation
State:
- pend_v[k] and pend_reg[k] hold a captured address/control set for master k.
- owner is the registered grant.
- dvalid/down is the data-phase owner.

Per-master rules:
- live_k = mk_htrans_i[1] & mk_hready_o.
- src_k = pend_v[k] ? pend_reg[k] : live inputs.
- req_k = pend_v[k] | live_k.

Grant sel, combinational:
- If s_hready_i=0: sel=owner (the slave address stage is frozen).
- Else if req[owner] and src_owner.htrans==SEQ: sel=owner (a burst is never split).
- Else if both masters request: fixed priority gives master 0. With ARB_ROUND_ROBIN_EN the winner is !owner.
- Else if one master requests: sel = that master.
- Else: sel=owner (parked).

Slave side:
- s_* address/control = src_sel.
- s_htrans_o = req_sel ? src_sel.htrans : IDLE.

Register updates on every edge:
- owner <= sel.
- When s_hready_i=1: dvalid <= req_sel & htrans[1], and down <= sel.
- pend_v[k] set when live_k & !(sel==k & s_hready_i); pend_reg[k] captures the live inputs in the same edge.
- pend_v[k] cleared when pend_v[k] & sel==k & s_hready_i.
- Set and clear of pend_v[k] never coincide.

Master-side ready and response:
- mk_hready_o = 0 if pend_v[k].
- Otherwise mk_hready_o = s_hready_i if dvalid & down==k.
- Otherwise mk_hready_o = 1.
- mk_hresp_o = s_hresp_i if dvalid & down==k, else OKAY.

s_hwdata_o = down ? m1_hwdata_i : m0_hwdata_i.

Reset values:
- owner=0, pend_v=0, dvalid=0, down=0.
- s_htrans_o=IDLE, mk_hready_o=1, mk_hresp_o=0, owner_o=0.

## Timing
- Uncontended transfer: zero added latency; address is presented to the slave in the same cycle it is driven.
- A buffered transfer is issued no earlier than the cycle after capture. Its master sees hready_o=0 until the issued transfer's data phase completes.
- Two-cycle ERROR responses pass through unchanged to the data owner only.
- Simultaneous first requests with owner=0:
  - Without round-robin: M0 is issued; M1 is captured; M1 is issued in the next cycle with s_hready_i=1.
  - With round-robin: M1 is issued first.
- Reset asserted mid-transfer clears all state immediately, including pending entries; those entries are lost.

## Configuration
- ARB_ROUND_ROBIN_EN defined: a contested arbitration grants !owner.
- ARB_ROUND_ROBIN_EN undefined: master 0 always wins contests.
- Burst locking and the buffering rules are identical in both builds.

## Test plan
- Single master, no contention: M0 reads 0x0000_0010 with s_hready_i=1. Expected: s_haddr_o=0x10 in the same cycle; m0_hready_o never low; m0_hrdata_o=s_hrdata_i; M1 sees hready=1 and hresp=0.
- Simultaneous NONSEQ: M0 0x100, M1 0x200, fixed priority. Expected: slave sees 0x100 then 0x200 on consecutive cycles; m1_hready_o=0 for exactly 1 cycle; owner_o is 0 then 1. In the ARB_ROUND_ROBIN_EN build the order is 0x200 then 0x100.
- Burst protection: M1 runs an INCR4 at 0x400 while M0 requests mid-burst. Expected: 0x400/404/408/40C are contiguous on the slave; M0's address is issued after 0x40C.
- Wait states: s_hready_i=0 for 3 cycles during an M0 data phase while M1 issues NONSEQ. Expected: s_haddr_o stays stable; M1 is captured (pend_v[1]=1); M1 is issued on the first s_hready_i=1 cycle.
- Error response: slave returns ERROR to M1's transfer. Expected: m1_hresp_o=1 for 2 cycles, with m1_hready_o 0 then 1; m0_hresp_o stays 0.
- Reset during a pending entry: assert hreset_n_i while pend_v[1]=1. Expected: all outputs return to their reset values asynchronously, and no stale transfer is issued after release.

Source files
------------

// File: rtl/ahb3lite_arbiter_2m.sv
// Two-master to one-slave AHB-Lite arbiter with a one-entry address holding buffer per master.
// Define ARB_ROUND_ROBIN_EN to alternate contested grants; otherwise master 0 wins contests.
module ahb3lite_arbiter_2m #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32
) (
    input  logic                  hclk_i,
    input  logic                  hreset_n_i,

    input  logic [HADDR_SIZE-1:0] m0_haddr_i,
    input  logic [1:0]            m0_htrans_i,
    input  logic                  m0_hwrite_i,
    input  logic [2:0]            m0_hsize_i,
    input  logic [2:0]            m0_hburst_i,
    input  logic [3:0]            m0_hprot_i,
    input  logic                  m0_hmastlock_i,
    input  logic [HDATA_SIZE-1:0] m0_hwdata_i,
    output logic [HDATA_SIZE-1:0] m0_hrdata_o,
    output logic                  m0_hready_o,
    output logic                  m0_hresp_o,

    input  logic [HADDR_SIZE-1:0] m1_haddr_i,
    input  logic [1:0]            m1_htrans_i,
    input  logic                  m1_hwrite_i,
    input  logic [2:0]            m1_hsize_i,
    input  logic [2:0]            m1_hburst_i,
    input  logic [3:0]            m1_hprot_i,
    input  logic                  m1_hmastlock_i,
    input  logic [HDATA_SIZE-1:0] m1_hwdata_i,
    output logic [HDATA_SIZE-1:0] m1_hrdata_o,
    output logic                  m1_hready_o,
    output logic                  m1_hresp_o,

    output logic [HADDR_SIZE-1:0] s_haddr_o,
    output logic [1:0]            s_htrans_o,
    output logic                  s_hwrite_o,
    output logic [2:0]            s_hsize_o,
    output logic [2:0]            s_hburst_o,
    output logic [3:0]            s_hprot_o,
    output logic                  s_hmastlock_o,
    output logic [HDATA_SIZE-1:0] s_hwdata_o,
    input  logic [HDATA_SIZE-1:0] s_hrdata_i,
    input  logic                  s_hready_i,
    input  logic                  s_hresp_i,

    output logic                  owner_o
);

    localparam logic [1:0] HT_IDLE = 2'b00;
    localparam logic [1:0] HT_SEQ  = 2'b11;

    typedef struct packed {
        logic [HADDR_SIZE-1:0] haddr;
        logic [1:0]            htrans;
        logic                  hwrite;
        logic [2:0]            hsize;
        logic [2:0]            hburst;
        logic [3:0]            hprot;
        logic                  hmastlock;
    } ctrl_t;

    ctrl_t       w_in       [2];
    ctrl_t       w_src      [2];
    ctrl_t       r_pend_reg [2];
    ctrl_t       w_out;
    logic [1:0]  r_pend_v;
    logic        r_owner;
    logic        r_dvalid;
    logic        r_down;
    logic [1:0]  w_hready;
    logic [1:0]  w_hresp;
    logic [1:0]  w_live;
    logic [1:0]  w_req;
    logic [1:0]  w_pset;
    logic [1:0]  w_pclr;
    logic        w_sel;

    assign w_in[0] = {m0_haddr_i, m0_htrans_i, m0_hwrite_i, m0_hsize_i,
                      m0_hburst_i, m0_hprot_i, m0_hmastlock_i};
    assign w_in[1] = {m1_haddr_i, m1_htrans_i, m1_hwrite_i, m1_hsize_i,
                      m1_hburst_i, m1_hprot_i, m1_hmastlock_i};

    // A master with a buffered entry is stalled until that entry's data phase is done.
    always_comb begin
        w_hready = 2'b11;
        w_hresp  = 2'b00;
        w_live   = 2'b00;
        w_req    = 2'b00;
        for (int k = 0; k < 2; k++) begin
            if (r_pend_v[k])
                w_hready[k] = 1'b0;
            else if (r_dvalid && (r_down == 1'(k)))
                w_hready[k] = s_hready_i;
            if (r_dvalid && (r_down == 1'(k)))
                w_hresp[k] = s_hresp_i;
            w_live[k] = w_in[k].htrans[1] & w_hready[k];
            w_req[k]  = r_pend_v[k] | w_live[k];
            w_src[k]  = r_pend_v[k] ? r_pend_reg[k] : w_in[k];
        end
    end

    always_comb begin
        w_sel = r_owner;
        if (!s_hready_i)
            w_sel = r_owner;
        else if (w_req[r_owner] && (w_src[r_owner].htrans == HT_SEQ))
            w_sel = r_owner;
        else if (w_req[0] && w_req[1])
`ifdef ARB_ROUND_ROBIN_EN
            w_sel = ~r_owner;
`else
            w_sel = 1'b0;
`endif
        else if (w_req[0])
            w_sel = 1'b0;
        else if (w_req[1])
            w_sel = 1'b1;
    end

    always_comb begin
        w_pset = 2'b00;
        w_pclr = 2'b00;
        for (int k = 0; k < 2; k++) begin
            w_pset[k] = w_live[k] & ~((w_sel == 1'(k)) & s_hready_i);
            w_pclr[k] = r_pend_v[k] & (w_sel == 1'(k)) & s_hready_i;
        end
    end

    assign w_out         = w_src[w_sel];
    assign s_haddr_o     = w_out.haddr;
    assign s_htrans_o    = w_req[w_sel] ? w_out.htrans : HT_IDLE;
    assign s_hwrite_o    = w_out.hwrite;
    assign s_hsize_o     = w_out.hsize;
    assign s_hburst_o    = w_out.hburst;
    assign s_hprot_o     = w_out.hprot;
    assign s_hmastlock_o = w_out.hmastlock;
    assign s_hwdata_o    = r_down ? m1_hwdata_i : m0_hwdata_i;

    assign m0_hrdata_o = s_hrdata_i;
    assign m1_hrdata_o = s_hrdata_i;
    assign m0_hready_o = w_hready[0];
    assign m1_hready_o = w_hready[1];
    assign m0_hresp_o  = w_hresp[0];
    assign m1_hresp_o  = w_hresp[1];
    assign owner_o     = r_owner;

    // Address stage -> data stage boundary
    always_ff @(posedge hclk_i or negedge hreset_n_i) begin
        if (!hreset_n_i) begin
            r_owner  <= 1'b0;
            r_dvalid <= 1'b0;
            r_down   <= 1'b0;
            r_pend_v <= 2'b00;
        end else begin
            r_owner <= w_sel;
            if (s_hready_i) begin
                r_dvalid <= w_req[w_sel] & w_out.htrans[1];
                r_down   <= w_sel;
            end
            for (int k = 0; k < 2; k++) begin
                if (w_pset[k])
                    r_pend_v[k] <= 1'b1;
                else if (w_pclr[k])
                    r_pend_v[k] <= 1'b0;
            end
        end
    end

    always_ff @(posedge hclk_i) begin
        for (int k = 0; k < 2; k++) begin
            if (w_pset[k])
                r_pend_reg[k] <= w_in[k];
        end
    end

endmodule

// File: tb/tb_ahb3lite_arbiter_2m.sv
// Directed self-checking bench for ahb3lite_arbiter_2m (honours ARB_ROUND_ROBIN_EN if defined).
module tb_ahb3lite_arbiter_2m;

    localparam int AW = 32;
    localparam int DW = 32;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam logic [1:0]    IDLE = 2'b00;
    localparam logic [1:0]    NSEQ = 2'b10;
    localparam logic [1:0]    SEQ  = 2'b11;
    localparam logic [DW-1:0] WD0  = 32'h1111_0000;
    localparam logic [DW-1:0] WD1  = 32'h2222_0000;

    logic          hclk = 1'b0;
    logic          hreset_n;
    logic [AW-1:0] m0_haddr, m1_haddr, s_haddr;
    logic [1:0]    m0_htrans, m1_htrans, s_htrans;
    logic          m0_hwrite, m1_hwrite, s_hwrite;
    logic [2:0]    m0_hsize, m1_hsize, s_hsize;
    logic [2:0]    m0_hburst, m1_hburst, s_hburst;
    logic [3:0]    m0_hprot, m1_hprot, s_hprot;
    logic          m0_hmastlock, m1_hmastlock, s_hmastlock;
    logic [DW-1:0] m0_hwdata, m1_hwdata, s_hwdata;
    logic [DW-1:0] m0_hrdata, m1_hrdata, s_hrdata;
    logic          m0_hready, m1_hready, s_hready;
    logic          m0_hresp, m1_hresp, s_hresp;
    logic          owner;

    int n_chk = 0;
    int n_err = 0;

    always #5 hclk = ~hclk;

    ahb3lite_arbiter_2m #(.HADDR_SIZE(AW), .HDATA_SIZE(DW)) dut (
        .hclk_i(hclk), .hreset_n_i(hreset_n),
        .m0_haddr_i(m0_haddr), .m0_htrans_i(m0_htrans), .m0_hwrite_i(m0_hwrite),
        .m0_hsize_i(m0_hsize), .m0_hburst_i(m0_hburst), .m0_hprot_i(m0_hprot),
        .m0_hmastlock_i(m0_hmastlock), .m0_hwdata_i(m0_hwdata), .m0_hrdata_o(m0_hrdata),
        .m0_hready_o(m0_hready), .m0_hresp_o(m0_hresp),
        .m1_haddr_i(m1_haddr), .m1_htrans_i(m1_htrans), .m1_hwrite_i(m1_hwrite),
        .m1_hsize_i(m1_hsize), .m1_hburst_i(m1_hburst), .m1_hprot_i(m1_hprot),
        .m1_hmastlock_i(m1_hmastlock), .m1_hwdata_i(m1_hwdata), .m1_hrdata_o(m1_hrdata),
        .m1_hready_o(m1_hready), .m1_hresp_o(m1_hresp),
        .s_haddr_o(s_haddr), .s_htrans_o(s_htrans), .s_hwrite_o(s_hwrite),
        .s_hsize_o(s_hsize), .s_hburst_o(s_hburst), .s_hprot_o(s_hprot),
        .s_hmastlock_o(s_hmastlock), .s_hwdata_o(s_hwdata), .s_hrdata_i(s_hrdata),
        .s_hready_i(s_hready), .s_hresp_i(s_hresp),
        .owner_o(owner)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv0(input logic [31:0] a, input logic [1:0] t, input logic w, input logic [2:0] b);
        m0_haddr = a; m0_htrans = t; m0_hwrite = w; m0_hburst = b;
    endtask

    task automatic drv1(input logic [31:0] a, input logic [1:0] t, input logic w, input logic [2:0] b);
        m1_haddr = a; m1_htrans = t; m1_hwrite = w; m1_hburst = b;
    endtask

    task automatic next();
        @(posedge hclk);
        #1;
    endtask

    initial begin
        hreset_n = 1'b0;
        drv0(32'h0, IDLE, 1'b0, 3'b000);
        drv1(32'h0, IDLE, 1'b0, 3'b000);
        m0_hsize = 3'b010; m1_hsize = 3'b010;
        m0_hprot = 4'b0011; m1_hprot = 4'b0011;
        m0_hmastlock = 1'b0; m1_hmastlock = 1'b0;
        m0_hwdata = WD0; m1_hwdata = WD1;
        s_hrdata = 32'h0; s_hready = 1'b1; s_hresp = 1'b0;

        // reset values
        #2;
        chk("rst_htrans", 32'(s_htrans), 32'(IDLE));
        chk("rst_m0_hready", 32'(m0_hready), 32'h1);
        chk("rst_m1_hready", 32'(m1_hready), 32'h1);
        chk("rst_m0_hresp", 32'(m0_hresp), 32'h0);
        chk("rst_m1_hresp", 32'(m1_hresp), 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        next(); next();
        hreset_n = 1'b1;

        // single master read, zero added latency
        drv0(32'h0000_0010, NSEQ, 1'b0, 3'b000);
        #2;
        chk("t1_addr", s_haddr, 32'h10);
        chk("t1_htrans", 32'(s_htrans), 32'(NSEQ));
        chk("t1_hsize", 32'(s_hsize), 32'h2);
        chk("t1_m0_hready_a", 32'(m0_hready), 32'h1);
        next();
        drv0(32'h0000_0010, IDLE, 1'b0, 3'b000);
        s_hrdata = 32'hDEAD_BEEF;
        #2;
        chk("t1_m0_hrdata", m0_hrdata, 32'hDEAD_BEEF);
        chk("t1_m0_hready_d", 32'(m0_hready), 32'h1);
        chk("t1_m1_hready", 32'(m1_hready), 32'h1);
        chk("t1_m1_hresp", 32'(m1_hresp), 32'h0);
        chk("t1_idle", 32'(s_htrans), 32'(IDLE));
        next();

        // simultaneous NONSEQ writes
        drv0(32'h100, NSEQ, 1'b1, 3'b000);
        drv1(32'h200, NSEQ, 1'b1, 3'b000);
        #2;
        chk("t2_c0_addr", s_haddr, RR ? 32'h200 : 32'h100);
        chk("t2_c0_owner", 32'(owner), 32'h0);
        chk("t2_c0_m0_hready", 32'(m0_hready), 32'h1);
        chk("t2_c0_m1_hready", 32'(m1_hready), 32'h1);
        next();
        drv0(32'h100, IDLE, 1'b1, 3'b000);
        drv1(32'h200, IDLE, 1'b1, 3'b000);
        #2;
        chk("t2_c1_addr", s_haddr, RR ? 32'h100 : 32'h200);
        chk("t2_c1_htrans", 32'(s_htrans), 32'(NSEQ));
        chk("t2_c1_m0_hready", 32'(m0_hready), RR ? 32'h0 : 32'h1);
        chk("t2_c1_m1_hready", 32'(m1_hready), RR ? 32'h1 : 32'h0);
        chk("t2_c1_hwdata", s_hwdata, RR ? WD1 : WD0);
        chk("t2_c1_owner", 32'(owner), RR ? 32'h1 : 32'h0);
        next();
        #2;
        chk("t2_c2_m0_hready", 32'(m0_hready), 32'h1);
        chk("t2_c2_m1_hready", 32'(m1_hready), 32'h1);
        chk("t2_c2_hwdata", s_hwdata, RR ? WD0 : WD1);
        chk("t2_c2_owner", 32'(owner), RR ? 32'h0 : 32'h1);
        chk("t2_c2_idle", 32'(s_htrans), 32'(IDLE));
        next();

        // INCR4 burst by M1, M0 requests mid-burst
        drv1(32'h400, NSEQ, 1'b0, 3'b011);
        #2;
        chk("t3_b0", s_haddr, 32'h400);
        next();
        drv1(32'h404, SEQ, 1'b0, 3'b011);
        drv0(32'h500, NSEQ, 1'b0, 3'b000);
        #2;
        chk("t3_b1", s_haddr, 32'h404);
        chk("t3_b1_htrans", 32'(s_htrans), 32'(SEQ));
        chk("t3_b1_m0_hready", 32'(m0_hready), 32'h1);
        next();
        drv1(32'h408, SEQ, 1'b0, 3'b011);
        drv0(32'h500, IDLE, 1'b0, 3'b000);
        #2;
        chk("t3_b2", s_haddr, 32'h408);
        chk("t3_b2_m0_hready", 32'(m0_hready), 32'h0);
        next();
        drv1(32'h40C, SEQ, 1'b0, 3'b011);
        #2;
        chk("t3_b3", s_haddr, 32'h40C);
        chk("t3_b3_m0_hready", 32'(m0_hready), 32'h0);
        next();
        drv1(32'h40C, IDLE, 1'b0, 3'b000);
        #2;
        chk("t3_m0_addr", s_haddr, 32'h500);
        chk("t3_m0_htrans", 32'(s_htrans), 32'(NSEQ));
        chk("t3_m0_hready_a", 32'(m0_hready), 32'h0);
        chk("t3_m1_hready", 32'(m1_hready), 32'h1);
        next();
        #2;
        chk("t3_m0_hready_d", 32'(m0_hready), 32'h1);
        chk("t3_idle", 32'(s_htrans), 32'(IDLE));
        next();

        // wait states on M0 data phase while M1 issues
        drv0(32'h600, NSEQ, 1'b0, 3'b000);
        #2;
        chk("t4_m0_addr", s_haddr, 32'h600);
        next();
        drv0(32'h600, IDLE, 1'b0, 3'b000);
        drv1(32'h700, NSEQ, 1'b0, 3'b000);
        s_hready = 1'b0;
        #2;
        chk("t4_w0_addr", s_haddr, 32'h600);
        chk("t4_w0_m0_hready", 32'(m0_hready), 32'h0);
        chk("t4_w0_m1_hready", 32'(m1_hready), 32'h1);
        next();
        drv1(32'h700, IDLE, 1'b0, 3'b000);
        #2;
        chk("t4_w1_addr", s_haddr, 32'h600);
        chk("t4_w1_m1_hready", 32'(m1_hready), 32'h0);
        next();
        #2;
        chk("t4_w2_addr", s_haddr, 32'h600);
        chk("t4_w2_m1_hready", 32'(m1_hready), 32'h0);
        next();
        s_hready = 1'b1;
        #2;
        chk("t4_m1_addr", s_haddr, 32'h700);
        chk("t4_m1_htrans", 32'(s_htrans), 32'(NSEQ));
        chk("t4_m0_hready", 32'(m0_hready), 32'h1);
        chk("t4_m1_hready_a", 32'(m1_hready), 32'h0);
        next();
        #2;
        chk("t4_m1_hready_d", 32'(m1_hready), 32'h1);
        next();

        // two-cycle ERROR to M1
        drv1(32'h800, NSEQ, 1'b0, 3'b000);
        #2;
        chk("t5_addr", s_haddr, 32'h800);
        next();
        drv1(32'h800, IDLE, 1'b0, 3'b000);
        s_hready = 1'b0; s_hresp = 1'b1;
        #2;
        chk("t5_e0_m1_hresp", 32'(m1_hresp), 32'h1);
        chk("t5_e0_m1_hready", 32'(m1_hready), 32'h0);
        chk("t5_e0_m0_hresp", 32'(m0_hresp), 32'h0);
        chk("t5_e0_m0_hready", 32'(m0_hready), 32'h1);
        next();
        s_hready = 1'b1;
        #2;
        chk("t5_e1_m1_hresp", 32'(m1_hresp), 32'h1);
        chk("t5_e1_m1_hready", 32'(m1_hready), 32'h1);
        chk("t5_e1_m0_hresp", 32'(m0_hresp), 32'h0);
        next();
        s_hresp = 1'b0;
        #2;
        chk("t5_after_m1_hresp", 32'(m1_hresp), 32'h0);
        next();

        // reset while M1 has a pending entry
        drv0(32'h900, NSEQ, 1'b0, 3'b000);
        drv1(32'hA00, NSEQ, 1'b0, 3'b000);
        #2;
        chk("t6_c0_addr", s_haddr, 32'h900);
        next();
        drv0(32'h900, IDLE, 1'b0, 3'b000);
        drv1(32'hA00, IDLE, 1'b0, 3'b000);
        #2;
        chk("t6_pend_addr", s_haddr, 32'hA00);
        chk("t6_pend_m1_hready", 32'(m1_hready), 32'h0);
        #1;
        hreset_n = 1'b0;
        #1;
        chk("t6_rst_htrans", 32'(s_htrans), 32'(IDLE));
        chk("t6_rst_m1_hready", 32'(m1_hready), 32'h1);
        chk("t6_rst_m0_hready", 32'(m0_hready), 32'h1);
        chk("t6_rst_owner", 32'(owner), 32'h0);
        chk("t6_rst_m0_hresp", 32'(m0_hresp), 32'h0);
        next(); next();
        hreset_n = 1'b1;
        #2;
        chk("t6_rel_htrans", 32'(s_htrans), 32'(IDLE));
        chk("t6_rel_m1_hready", 32'(m1_hready), 32'h1);
        next();
        #2;
        chk("t6_rel2_htrans", 32'(s_htrans), 32'(IDLE));
        chk("t6_rel2_owner", 32'(owner), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
